serial_subtractor: RTL

//  - Bit-serial unsigned subtractor: computes DIFF = A - B, LSB first, one bit per clock.
//  - Datapath per bit: one full-subtractor cell plus a registered borrow.
//  - Counterpart to the combinational adder cells: subtract instead of add,

---
 rtl/serial_subtractor_pkg.sv | 20 ++
 rtl/serial_subtractor_full_subtractor_dataflow.sv | 14 +
 rtl/serial_subtractor.sv | 129 ++++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the bit-counter width helper.
package serial_subtractor_pkg;

  // Controller states; encodings are fixed so other blocks can decode them.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of the bit counter: max(1, clog2(width)), so a 1-bit build still
  // has a real (single-bit) counter.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor_dataflow.sv
// Single-bit full subtractor: d = x - y - bin, with bout the borrow out.
// Purely combinational.
module full_subtractor_dataflow (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor. Operands are captured on the input
// handshake, then one bit per clock is processed LSB first through a single
// full-subtractor cell with a registered borrow. The result is held in DONE
// until the consumer accepts it.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  state_t           state_reg;
  logic [WIDTH-1:0] ra_reg;
  logic [WIDTH-1:0] rb_reg;
  logic [WIDTH-1:0] dreg_reg;
  logic             br_reg;
  logic [CW-1:0]    cnt_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;

  // Shifted versions of the operand and result registers for one RUN step.
  logic [WIDTH-1:0] ra_next;
  logic [WIDTH-1:0] rb_next;
  logic [WIDTH-1:0] dreg_next;

  logic             d_bit;
  logic             bn_bit;

  // The only arithmetic: one cell working on bit 0 of the shift registers.
  full_subtractor_dataflow u_fs (
    .x    (ra_reg[0]),
    .y    (rb_reg[0]),
    .bin  (br_reg),
    .d    (d_bit),
    .bout (bn_bit)
  );

  // Right-shift network. Operands shift in zeros at the top; the result
  // register receives the freshly computed bit at its MSB so that after
  // WIDTH steps bit 0 holds the first (LSB) difference bit.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == WIDTH - 1) begin : g_msb
        assign ra_next[gi]   = 1'b0;
        assign rb_next[gi]   = 1'b0;
        assign dreg_next[gi] = d_bit;
      end else begin : g_body
        assign ra_next[gi]   = ra_reg[gi+1];
        assign rb_next[gi]   = rb_reg[gi+1];
        assign dreg_next[gi] = dreg_reg[gi+1];
      end
    end
  endgenerate

  // Controller and datapath registers; handshake outputs are registered
  // alongside the state so they track it exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      ra_reg        <= '0;
      rb_reg        <= '0;
      dreg_reg      <= '0;
      br_reg        <= 1'b0;
      cnt_reg       <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            ra_reg       <= a;
            rb_reg       <= b;
            dreg_reg     <= '0;
            br_reg       <= 1'b0;
            cnt_reg      <= '0;
            state_reg    <= ST_RUN;
            in_ready_reg <= 1'b0;
          end
        end
        ST_RUN: begin
          ra_reg   <= ra_next;
          rb_reg   <= rb_next;
          dreg_reg <= dreg_next;
          br_reg   <= bn_bit;
          cnt_reg  <= cnt_reg + CNT_ONE;
          if (cnt_reg == CNT_LAST) begin
            state_reg     <= ST_DONE;
            out_valid_reg <= 1'b1;
          end
        end
        ST_DONE: begin
          // Result registers are left untouched here so backpressure
          // cannot disturb the presented value.
          if (out_ready) begin
            state_reg     <= ST_IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_reg;
  assign out_valid  = out_valid_reg;
  assign diff       = dreg_reg;
  assign borrow_out = br_reg;

endmodule
